// File: rtl/ramctrl_pkg.sv
// ---------------------------------------------------------------------------
// ramctrl_pkg
// Definitions shared between the instruction cache and the RAM controller
// instruction port: line geometry, the word-select field of the CPU word
// address, the cache FSM state encoding and the word-select helper.
// ---------------------------------------------------------------------------
package ramctrl_pkg;

  localparam int LINE_W   = 128;  // bits per cache line / RAM burst
  localparam int LADDR_W  = 25;   // line address width on the instruction port
  localparam int WORD_W   = 32;   // CPU fetch word
  localparam int WSEL_LSB = 0;    // word-in-line field position in cpu_addr
  localparam int WSEL_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_FILL    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  // Word 0 of a line lives in the most significant 32 bits.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] sel);
    logic [WORD_W-1:0] w;
    w = line[127:96];
    case (sel)
      2'd0: w = line[127:96];
      2'd1: w = line[95:64];
      2'd2: w = line[63:32];
      2'd3: w = line[31:0];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_sram.sv
// ---------------------------------------------------------------------------
// icache_sram
// Single-port RAM with synchronous read (read-before-write on the same
// address). Contents are never reset.
// Ports:
//   clk    clock
//   addr   read/write address
//   we     write enable
//   wdata  write data
//   rdata  registered read data of the previous cycle's address
// ---------------------------------------------------------------------------
module icache_sram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 128,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped read-only instruction cache, 16-byte lines, between the CPU
// fetch port and the RAM controller's 128-bit instruction port.
// Optional feature macro: ICACHE_INV_EN adds cpu_inv (invalidate all lines).
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   cpu_inv          (ICACHE_INV_EN only) invalidate-all request, taken in IDLE
//   cpu_stb/cpu_addr fetch request, 27-bit word address, held until ack/timeout
//   cpu_dout         fetched word, valid with cpu_ack
//   cpu_ack          one-cycle pulse: word delivered
//   cpu_timeout      one-cycle pulse: fill reported an illegal address
//   mem_stb/mem_addr line fill request and line address (cpu_addr[26:2])
//   mem_din          fill line, word 0 in [127:96]
//   mem_ack          fill complete, mem_din valid
//   mem_timeout      fill failed (wins over mem_ack)
// ---------------------------------------------------------------------------
module icache
  import ramctrl_pkg::*;
#(
  parameter int IDX_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
`ifdef ICACHE_INV_EN
  input  logic                cpu_inv,
`endif
  input  logic                cpu_stb,
  input  logic [26:0]         cpu_addr,
  output logic [WORD_W-1:0]   cpu_dout,
  output logic                cpu_ack,
  output logic                cpu_timeout,
  output logic                mem_stb,
  output logic [LADDR_W-1:0]  mem_addr,
  input  logic [LINE_W-1:0]   mem_din,
  input  logic                mem_ack,
  input  logic                mem_timeout
);

  localparam int TAG_BITS = LADDR_W - IDX_BITS;
  localparam int LINES    = 1 << IDX_BITS;

  state_t                state, state_nxt;
  logic [LINES-1:0]      valid;
  logic [LINE_W-1:0]     line_q;
  logic [LINE_W-1:0]     data_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WSEL_W-1:0]     wsel;
  logic                  hit;
  logic                  fill_we;
  logic                  inv_clr;

  assign idx      = cpu_addr[IDX_BITS+1:2];
  assign tag      = cpu_addr[26:IDX_BITS+2];
  assign wsel     = cpu_addr[WSEL_LSB+WSEL_W-1:WSEL_LSB];
  assign mem_addr = cpu_addr[26:2];

  // Arrays are read every cycle at the current index; cpu_addr is stable
  // from IDLE onwards, so LOOKUP sees the line/tag selected in IDLE.
  assign hit = valid[idx] && (tag_q == tag);

  // A timeout wins over a simultaneous ack, and a fill caught by reset
  // must not land in the arrays.
  assign fill_we = (state == ST_FILL) && mem_ack && !mem_timeout && rst;

  icache_sram #(.DEPTH(LINES), .WIDTH(LINE_W), .AW(IDX_BITS)) u_data (
    .clk   (clk),
    .addr  (idx),
    .we    (fill_we),
    .wdata (mem_din),
    .rdata (data_q)
  );

  icache_sram #(.DEPTH(LINES), .WIDTH(TAG_BITS), .AW(IDX_BITS)) u_tag (
    .clk   (clk),
    .addr  (idx),
    .we    (fill_we),
    .wdata (tag),
    .rdata (tag_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      valid  <= '0;
      line_q <= '0;
    end else begin
      state <= state_nxt;
      if (inv_clr)      valid      <= '0;
      else if (fill_we) valid[idx] <= 1'b1;
      if (fill_we) line_q <= mem_din;
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_ack     = 1'b0;
    cpu_timeout = 1'b0;
    mem_stb     = 1'b0;
    inv_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef ICACHE_INV_EN
        // Invalidate takes the cycle; a pending fetch is seen next cycle.
        if (cpu_inv)      inv_clr   = 1'b1;
        else if (cpu_stb) state_nxt = ST_LOOKUP;
`else
        if (cpu_stb) state_nxt = ST_LOOKUP;
`endif
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_ack   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_stb = 1'b1;
        if (mem_timeout)  state_nxt = ST_ERROR;
        else if (mem_ack) state_nxt = ST_DELIVER;
      end
      ST_DELIVER: begin
        cpu_ack   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        cpu_timeout = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_dout = word_sel((state == ST_DELIVER) ? line_q : data_q, wsel);

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
// Directed and randomized fetches against a slot-level cache model: each of
// the 512 slots remembers which line address it holds and that line's data;
// backing memory is a table of explicit lines plus a hash for the rest.
// ---------------------------------------------------------------------------
module tb_icache;

  localparam int LINES = 512;

  logic         clk = 1'b0;
  logic         rst;
`ifdef ICACHE_INV_EN
  logic         cpu_inv;
`endif
  logic         cpu_stb;
  logic [26:0]  cpu_addr;
  logic [31:0]  cpu_dout;
  logic         cpu_ack;
  logic         cpu_timeout;
  logic         mem_stb;
  logic [24:0]  mem_addr;
  logic [127:0] mem_din;
  logic         mem_ack;
  logic         mem_timeout;

  int checks   = 0;
  int failures = 0;

  // model state
  bit           mvalid [LINES];
  logic [24:0]  mla    [LINES];
  logic [127:0] mdata  [LINES];
  logic [127:0] mem_img [logic [24:0]];

  icache dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ICACHE_INV_EN
    .cpu_inv     (cpu_inv),
`endif
    .cpu_stb     (cpu_stb),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .cpu_timeout (cpu_timeout),
    .mem_stb     (mem_stb),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_ack     (mem_ack),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [127:0] get_line(input logic [24:0] la);
    logic [31:0] a;
    if (mem_img.exists(la)) return mem_img[la];
    a = 32'(la);
    return {a * 32'h9E3779B1, a ^ 32'hDEADBEEF, ~a, a + 32'h13579BDF};
  endfunction

  function automatic logic [31:0] pick_word(input logic [127:0] ln, input logic [1:0] w);
    logic [127:0] s;
    s = ln >> (32 * (3 - int'(w)));
    return s[31:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 = mem_ack, 1 = mem_timeout, 2 = both (timeout must win).
  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic fetch(input logic [26:0] a, input int lat, input int kind,
                       input string nm, output bit was_miss, output logic [31:0] dout);
    logic [24:0]  la;
    int           slot;
    bit           hit;
    logic [127:0] ln;
    int           cyc, stb_cnt, resp_cyc, done_cyc;
    bit           got_ack, got_to, addr_ok;
    la       = a[26:2];
    slot     = int'(la) % LINES;
    hit      = mvalid[slot] && (mla[slot] == la);
    ln       = hit ? mdata[slot] : get_line(la);
    cyc      = 0;
    stb_cnt  = 0;
    resp_cyc = -1;
    done_cyc = -1;
    got_ack  = 1'b0;
    got_to   = 1'b0;
    addr_ok  = 1'b1;
    dout     = '0;
    cpu_addr = a;
    cpu_stb  = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      tick();
      cyc++;
      mem_ack     = 1'b0;
      mem_timeout = 1'b0;
      mem_din     = '0;
      if (mem_stb) begin
        stb_cnt++;
        if (mem_addr !== la) addr_ok = 1'b0;
        if (stb_cnt == lat) begin
          resp_cyc    = cyc;
          mem_ack     = (kind != 1);
          mem_timeout = (kind != 0);
          mem_din     = ln;
        end
      end
      if (cpu_ack || cpu_timeout) begin
        done_cyc = cyc;
        got_ack  = cpu_ack;
        got_to   = cpu_timeout;
        dout     = cpu_dout;
      end
    end
    cpu_stb     = 1'b0;
    mem_ack     = 1'b0;
    mem_timeout = 1'b0;
    was_miss    = (stb_cnt > 0);
    chk({nm, "_done"}, done_cyc >= 0, 1);
    if (hit) begin
      chk({nm, "_hit_stb"}, stb_cnt, 0);
      chk({nm, "_hit_lat"}, done_cyc, 1);
      chk({nm, "_hit_ack"}, {got_ack, got_to}, 2'b10);
      chk({nm, "_hit_dout"}, dout, pick_word(ln, a[1:0]));
    end else begin
      chk({nm, "_fill_cycles"}, stb_cnt, lat);
      chk({nm, "_mem_addr"}, addr_ok, 1);
      chk({nm, "_miss_lat"}, done_cyc, resp_cyc + 1);
      if (kind == 0) begin
        chk({nm, "_miss_ack"}, {got_ack, got_to}, 2'b10);
        chk({nm, "_miss_dout"}, dout, pick_word(ln, a[1:0]));
        mvalid[slot] = 1'b1;
        mla[slot]    = la;
        mdata[slot]  = ln;
      end else begin
        chk({nm, "_timeout"}, {got_ack, got_to}, 2'b01);
      end
    end
    tick();
    chk({nm, "_quiet"}, {cpu_ack, cpu_timeout, mem_stb}, 3'b000);
  endtask

  initial begin
    bit          miss;
    logic [31:0] d;
    bit          saw;
    rst         = 1'b0;
`ifdef ICACHE_INV_EN
    cpu_inv     = 1'b0;
`endif
    cpu_stb     = 1'b0;
    cpu_addr    = '0;
    mem_din     = '0;
    mem_ack     = 1'b0;
    mem_timeout = 1'b0;
    model_clear();
    mem_img[25'h4] = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    tick();
    tick();
    chk("reset_outputs", {cpu_ack, cpu_timeout, mem_stb}, 3'b000);
    rst = 1'b1;
    tick();

    // cold miss, then hit on another word of the same line
    fetch(27'h0000010, 5, 0, "cold", miss, d);
    chk("cold_is_miss", miss, 1);
    chk("cold_word", d, 32'h00112233);
    fetch(27'h0000013, 1, 0, "hit", miss, d);
    chk("hit_no_fill", miss, 0);
    chk("hit_word", d, 32'hCCDDEEFF);

    // same index, different tag evicts the line
    fetch(27'h0000810, 3, 0, "conflict", miss, d);
    chk("conflict_is_miss", miss, 1);
    fetch(27'h0000010, 2, 0, "reload", miss, d);
    chk("reload_is_miss", miss, 1);
    chk("reload_word", d, 32'h00112233);

    // downstream timeout leaves the line invalid
    fetch(27'h6000000, 4, 1, "to", miss, d);
    fetch(27'h6000000, 2, 0, "to_refetch", miss, d);
    chk("to_refetch_is_miss", miss, 1);
    fetch(27'h6000004, 2, 2, "both", miss, d);
    fetch(27'h6000004, 1, 0, "both_refetch", miss, d);
    chk("both_refetch_is_miss", miss, 1);

    // reset in the middle of a fill
    cpu_addr = 27'h0000020;
    cpu_stb  = 1'b1;
    saw      = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      tick();
      saw = mem_stb;
    end
    chk("rstfill_stb_seen", saw, 1);
    rst = 1'b0;
    tick();
    chk("rstfill_stb_drop", {mem_stb, cpu_ack, cpu_timeout}, 3'b000);
    rst     = 1'b1;
    cpu_stb = 1'b0;
    model_clear();
    tick();
    fetch(27'h0000010, 2, 0, "post_rst", miss, d);
    chk("post_rst_is_miss", miss, 1);

`ifdef ICACHE_INV_EN
    fetch(27'h0000011, 1, 0, "inv_pre", miss, d);
    chk("inv_pre_hit", miss, 0);
    cpu_addr = 27'h0000011;
    cpu_inv  = 1'b1;
    cpu_stb  = 1'b1;
    tick();
    chk("inv_cycle", {cpu_ack, mem_stb}, 2'b00);
    cpu_inv = 1'b0;
    model_clear();
    fetch(27'h0000011, 2, 0, "inv_post", miss, d);
    chk("inv_post_is_miss", miss, 1);
    chk("inv_post_word", d, 32'h44556677);
`endif

    // randomized traffic over a small address pool so hits and evictions mix
    for (int n = 0; n < 60; n++) begin
      logic [24:0] la;
      int          r;
      int          kind;
      la   = 25'(($urandom_range(0, 3) << 9) | $urandom_range(0, 7));
      r    = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      fetch({la, 2'($urandom_range(0, 3))}, $urandom_range(1, 6), kind, "rnd", miss, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and the RAM controller's 128-bit instruction port.
- On a hit it returns a 32-bit word from a 128-bit line. On a miss it fills the whole line over the inst_stb/inst_ack/inst_timeout handshake, then delivers the word.
- The line address sent downstream is 25 bits, so it drives the RAM controller's instruction-port inputs directly.

Parameters:
- IDX_BITS, 9, index width; LINES = 2**IDX_BITS lines of 16 bytes (default 8 KB). Legal range 4..12.
- TAG_BITS, 25-IDX_BITS, derived localparam; not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (clears on the rising edge where rst==0).
- cpu_stb  in  1  fetch request; held high with cpu_addr stable until cpu_ack or cpu_timeout.
- cpu_addr  in  27  word address; [26:2] is the line address, [1:0] is the word in the line.
- cpu_dout  out  32  fetched word; valid only while cpu_ack=1.
- cpu_ack  out  1  one-cycle pulse, word delivered.
- cpu_timeout  out  1  one-cycle pulse, downstream reported an illegal address.
- mem_stb  out  1  line fill request (to inst_stb).
- mem_addr  out  25  line address, always cpu_addr[26:2] (to inst_addr).
- mem_din  in  128  fill line (from inst_dout); bits [127:96] = word 0.
- mem_ack  in  1  fill complete; mem_din valid in the same cycle.
- mem_timeout  in  1  fill failed.

Behaviour:
- Storage:
  - data array LINES x 128, synchronous read;
  - tag array LINES x TAG_BITS, synchronous read;
  - valid vector LINES x 1 in flops.
  - Index = cpu_addr[IDX_BITS+1:2]; tag = cpu_addr[26:IDX_BITS+2].
- Word select: cpu_addr[1:0] 00 -> [127:96], 01 -> [95:64], 10 -> [63:32], 11 -> [31:0].
- States:
  - IDLE: arrays read at index. If cpu_stb -> LOOKUP, else stay.
  - LOOKUP: hit = valid[idx] & (tag_q==tag).
    - Hit: cpu_ack=1, cpu_dout from the data array output, -> IDLE.
    - Miss: -> FILL.
  - FILL: mem_stb=1, held until a response.
    - mem_ack: write mem_din to data[idx], tag to tag[idx], set valid[idx]; latch mem_din into line_q; -> DELIVER.
    - mem_timeout: no array write, valid untouched; -> ERROR.
    - Neither: stay.
  - DELIVER: cpu_ack=1, cpu_dout from line_q, -> IDLE.
  - ERROR: cpu_timeout=1, -> IDLE.
- Latency, counted from the cycle cpu_stb is first seen in IDLE:
  - hit: ack in the next cycle;
  - miss: ack 1 cycle after mem_ack.
- Minimum spacing between back-to-back hits is 2 cycles.
- cpu_ack and cpu_timeout are never high together; both are low in IDLE and FILL.
- mem_ack and mem_timeout are sampled only in FILL. If both are high, mem_timeout wins.
- cpu_stb is not re-sampled after IDLE. Dropping it mid-fill is a protocol violation: the fill still completes and the ack is still pulsed.
- Reset (rst==0):
  - state=IDLE, all valid bits cleared in that cycle;
  - cpu_ack=0, cpu_timeout=0, mem_stb=0, line_q=0;
  - array contents not cleared.
  - Reset during FILL abandons the fill with no array write; the downstream controller shares the reset.
- Same-index conflict: a fill overwrites the line (no associativity, no replacement choice).

Optional Feature:
- Macro ICACHE_INV_EN.
- Defined:
  - Adds port cpu_inv in 1.
  - cpu_inv high in IDLE clears all valid bits in that cycle; it has priority over cpu_stb, which is handled in the following cycle.
  - cpu_inv outside IDLE is ignored; the fetch unit holds it until it is accepted.
- Undefined: no port; valid bits are cleared only by reset.

Decomposition:
- Shared package (ramctrl_pkg): line width 128, line address width 25, word-select field position, state encoding constants.
- One sub-module, icache_sram: parameterised single-port synchronous-read RAM (depth, width), instantiated for data and for tag.
- Valid flops, FSM and word mux stay in icache.

Test Plan:
- Cold miss: after reset, cpu_addr=27'h0000010 (line 4, word 0); memory model returns 128'h00112233_44556677_8899AABB_CCDDEEFF after 5 cycles -> mem_stb high with mem_addr=25'h4; then cpu_ack with cpu_dout=32'h00112233 one cycle after mem_ack.
- Hit: repeat cpu_addr=27'h0000013 -> no mem_stb; cpu_ack in the cycle after LOOKUP entry, cpu_dout=32'hCCDDEEFF.
- Conflict: fetch 27'h0000810 (same index, different tag, IDX_BITS=9) -> miss and fill. Then 27'h0000010 misses again.
- Timeout: mem_timeout on a fill for 25'h1800000 -> cpu_timeout pulses once, no cpu_ack. A refetch still misses (valid not set).
- Reset mid-fill: drive rst=0 during FILL -> mem_stb=0 next cycle. After release, the earlier cached line misses.
- ICACHE_INV_EN: cpu_inv together with cpu_stb in IDLE -> all lines invalidated; the request is then processed as a miss.
